calc_seq_ctrl: RTL

- Sequencing controller for the a/b/c/e ratio-times-sine datapath.
- On a start request it loads the operand registers and checks for a zero divisor.
- It then runs the divider and the serial-to-parallel capture of e in parallel, starts the multiplier, latches the sine sign when the product completes, and signals result valid or error.
- Replaces the free-running enable/ok chaining with an explicit, timeout-guarded handshake FSM.

---
 rtl/calc_seq_ctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/calc_seq_ctrl.sv
// Sequencing controller for the a/b/c/e ratio-times-sine datapath: load, zero-divisor check,
// parallel divide + serial capture, multiply, sign latch, with timeout-guarded handshakes.
module calc_seq_ctrl #(
  parameter int SER_BITS    = 10,
  parameter int DIV_TIMEOUT = 64,
  parameter int MUL_TIMEOUT = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       div_zero,
  input  logic       div_ok,
  input  logic       mul_ok,
  input  logic       sign_in,
  output logic       op_ld,
  output logic       div_en,
  output logic       s2p_en,
  output logic       mul_en,
  output logic       sign_q,
  output logic       busy,
  output logic       y_valid,
  output logic [1:0] err_code
);

  localparam int BIT_W  = $clog2(SER_BITS + 1);
  localparam int MAX_TO = (DIV_TIMEOUT > MUL_TIMEOUT) ? DIV_TIMEOUT : MUL_TIMEOUT;
  localparam int CYC_W  = (MAX_TO > 1) ? $clog2(MAX_TO) : 1;

  localparam logic [BIT_W-1:0] BIT_FULL = BIT_W'(SER_BITS);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(SER_BITS - 1);
  localparam logic [CYC_W-1:0] DIV_LAST = CYC_W'(DIV_TIMEOUT - 1);
  localparam logic [CYC_W-1:0] MUL_LAST = CYC_W'(MUL_TIMEOUT - 1);

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_DIVZERO = 2'd1;
  localparam logic [1:0] ERR_DIV_TO  = 2'd2;
  localparam logic [1:0] ERR_MUL_TO  = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CHECK,
    RUN,
    MUL,
    DONE
  } state_t;

  state_t           state;
  logic [BIT_W-1:0] bit_cnt;
  logic [CYC_W-1:0] cyc_cnt;
  logic             div_done;

  // Outputs are assigned together with the transition that enters their state, so they
  // always line up with the state register and never see an input combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      cyc_cnt  <= '0;
      div_done <= 1'b0;
      op_ld    <= 1'b0;
      div_en   <= 1'b0;
      s2p_en   <= 1'b0;
      mul_en   <= 1'b0;
      sign_q   <= 1'b0;
      busy     <= 1'b0;
      y_valid  <= 1'b0;
      err_code <= ERR_OK;
    end else begin
      op_ld   <= 1'b0;
      y_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= LOAD;
            op_ld    <= 1'b1;
            busy     <= 1'b1;
            err_code <= ERR_OK;
          end
        end
        LOAD: begin
          state <= CHECK;
        end
        CHECK: begin
          if (div_zero) begin
            state    <= DONE;
            err_code <= ERR_DIVZERO;
            y_valid  <= 1'b1;
          end else begin
            state    <= RUN;
            div_en   <= 1'b1;
            s2p_en   <= 1'b1;
            bit_cnt  <= '0;
            cyc_cnt  <= '0;
            div_done <= 1'b0;
          end
        end
        RUN: begin
          cyc_cnt <= cyc_cnt + 1'b1;
          if (s2p_en) begin
            bit_cnt <= bit_cnt + 1'b1;
            s2p_en  <= (bit_cnt != BIT_LAST);
          end
          if (div_ok) begin
            div_done <= 1'b1;
            div_en   <= 1'b0;
          end
          // Timeout wins over a normal exit landing on the same cycle.
          if (cyc_cnt == DIV_LAST) begin
            state    <= DONE;
            err_code <= ERR_DIV_TO;
            y_valid  <= 1'b1;
            div_en   <= 1'b0;
            s2p_en   <= 1'b0;
          end else if ((div_done || div_ok) && bit_cnt == BIT_FULL) begin
            state   <= MUL;
            mul_en  <= 1'b1;
            div_en  <= 1'b0;
            cyc_cnt <= '0;
          end
        end
        MUL: begin
          cyc_cnt <= cyc_cnt + 1'b1;
          // A product arriving on the last allowed cycle still counts as success.
          if (mul_ok) begin
            state    <= DONE;
            sign_q   <= sign_in;
            err_code <= ERR_OK;
            y_valid  <= 1'b1;
            mul_en   <= 1'b0;
          end else if (cyc_cnt == MUL_LAST) begin
            state    <= DONE;
            err_code <= ERR_MUL_TO;
            y_valid  <= 1'b1;
            mul_en   <= 1'b0;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy   <= 1'b0;
          div_en <= 1'b0;
          s2p_en <= 1'b0;
          mul_en <= 1'b0;
        end
      endcase
    end
  end

endmodule
